// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - opcodes, FSM states, instruction classes and control-word type
package control_unit_pkg;

    localparam int MEM_WAIT_DEFAULT = 1;
    localparam int ALU_N            = 13;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_LD, CLS_LDI, CLS_IMM, CLS_ST, CLS_ALU3, CLS_UNARY, CLS_MULDIV,
        CLS_BR, CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_HALT
    } cls_t;

    // Enum value is also the bit position in the one-hot ALU field
    typedef enum logic [3:0] {
        ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_SHR,
        ALU_SHRA, ALU_SHL, ALU_ROR, ALU_ROL, ALU_NEG, ALU_NOT
    } alu_op_t;

    typedef struct packed {
        logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout;
        logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Rin, CONin, OUT_Portin;
        logic Gra, Grb, Grc, IncPC, PCSave;
        logic [ALU_N-1:0] alu;
        logic Read, read_mem, write_mem, CON_RESET, Run;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{CON_RESET: 1'b1, default: '0};

    function automatic logic [ALU_N-1:0] alu_onehot(alu_op_t op);
        return ALU_N'(1) << op;
    endfunction

    function automatic state_t last_step(cls_t cls);
        case (cls)
            CLS_LD, CLS_ST:                               return ST_T7;
            CLS_MULDIV, CLS_BR:                           return ST_T6;
            CLS_LDI, CLS_IMM, CLS_ALU3:                   return ST_T5;
            CLS_UNARY, CLS_JAL:                           return ST_T4;
            CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO:  return ST_T3;
            default:                                      return ST_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - instruction/flag inputs and control strobes between control unit and datapath
interface control_unit_if;

    logic [31:0] IR;
    logic        CON_FF;
    logic        stop;

    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout;
    logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Rin, CONin, OUT_Portin;
    logic Gra, Grb, Grc, IncPC, PCSave;
    logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic Read, read_mem, write_mem, CON_RESET, Run;

    modport master (
        input  IR, CON_FF, stop,
        output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout,
        output HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Rin, CONin, OUT_Portin,
        output Gra, Grb, Grc, IncPC, PCSave,
        output AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        output Read, read_mem, write_mem, CON_RESET, Run
    );

    modport slave (
        output IR, CON_FF, stop,
        input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout,
        input  HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Rin, CONin, OUT_Portin,
        input  Gra, Grb, Grc, IncPC, PCSave,
        input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
        input  Read, read_mem, write_mem, CON_RESET, Run
    );

endinterface

// File: rtl/control_unit_decode.sv
// rtl/control_unit_decode.sv - combinational opcode to instruction-class and ALU-op decode
module cu_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] opcode_i,
    output cls_t       cls_o,
    output alu_op_t    alu_o
);

    always_comb begin
        cls_o = CLS_NOP;
        alu_o = ALU_ADD;
        case (opcode_i)
            OP_LD:   cls_o = CLS_LD;
            OP_LDI:  cls_o = CLS_LDI;
            OP_ST:   cls_o = CLS_ST;
            OP_ADD:  cls_o = CLS_ALU3;
            OP_SUB:  begin cls_o = CLS_ALU3;   alu_o = ALU_SUB;  end
            OP_AND:  begin cls_o = CLS_ALU3;   alu_o = ALU_AND;  end
            OP_OR:   begin cls_o = CLS_ALU3;   alu_o = ALU_OR;   end
            OP_SHR:  begin cls_o = CLS_ALU3;   alu_o = ALU_SHR;  end
            OP_SHRA: begin cls_o = CLS_ALU3;   alu_o = ALU_SHRA; end
            OP_SHL:  begin cls_o = CLS_ALU3;   alu_o = ALU_SHL;  end
            OP_ROR:  begin cls_o = CLS_ALU3;   alu_o = ALU_ROR;  end
            OP_ROL:  begin cls_o = CLS_ALU3;   alu_o = ALU_ROL;  end
            OP_ADDI: cls_o = CLS_IMM;
            OP_ANDI: begin cls_o = CLS_IMM;    alu_o = ALU_AND;  end
            OP_ORI:  begin cls_o = CLS_IMM;    alu_o = ALU_OR;   end
            OP_MUL:  begin cls_o = CLS_MULDIV; alu_o = ALU_MUL;  end
            OP_DIV:  begin cls_o = CLS_MULDIV; alu_o = ALU_DIV;  end
            OP_NEG:  begin cls_o = CLS_UNARY;  alu_o = ALU_NEG;  end
            OP_NOT:  begin cls_o = CLS_UNARY;  alu_o = ALU_NOT;  end
            OP_BR:   cls_o = CLS_BR;
            OP_JR:   cls_o = CLS_JR;
            OP_JAL:  cls_o = CLS_JAL;
            OP_IN:   cls_o = CLS_IN;
            OP_OUT:  cls_o = CLS_OUT;
            OP_MFHI: cls_o = CLS_MFHI;
            OP_MFLO: cls_o = CLS_MFLO;
            OP_HALT: cls_o = CLS_HALT;
            default: cls_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control FSM sequencing fetch and per-class execute steps
module control_unit
    import control_unit_pkg::*;
#(
    parameter int MEM_WAIT = MEM_WAIT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    control_unit_if.master bus
);

    localparam int              CW       = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_WAIT - 1);

    state_t        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_q;
    logic          stop_seen_q, stop_seen_d;
    ctrl_t         out_q, out_d;
    cls_t          cls;
    alu_op_t       alu;

    cu_decode u_decode (
        .opcode_i (op_d),
        .cls_o    (cls),
        .alu_o    (alu)
    );

    function automatic state_t next_step(state_t st);
        case (st)
            ST_T2:   return ST_T3;
            ST_T3:   return ST_T4;
            ST_T4:   return ST_T5;
            ST_T5:   return ST_T6;
            ST_T6:   return ST_T7;
            default: return ST_T0;
        endcase
    endfunction

    function automatic ctrl_t ctrl_word(state_t st, cls_t c, alu_op_t op, logic con_ff);
        ctrl_t            w;
        logic [ALU_N-1:0] oh;
        w     = '0;
        oh    = alu_onehot(op);
        w.Run = (st != ST_RST) && (st != ST_HALT);
        case (st)
            ST_RST: w.CON_RESET = 1'b1;
            ST_T0:  begin w.IncPC = 1'b1; w.MARin = 1'b1; w.PCin = 1'b1; end
            ST_T1:  begin w.Read = 1'b1; w.read_mem = 1'b1; w.MDRin = 1'b1; end
            ST_T2:  begin w.MDRout = 1'b1; w.IRin = 1'b1; end
            ST_T3: case (c)
                CLS_LD, CLS_LDI, CLS_ST: begin w.Grb = 1'b1; w.BAout = 1'b1; w.Yin = 1'b1; end
                CLS_IMM, CLS_ALU3:       begin w.Grb = 1'b1; w.Rout = 1'b1; w.Yin = 1'b1; end
                CLS_UNARY:  begin w.Grb = 1'b1; w.Rout = 1'b1; w.Zin = 1'b1; w.alu = oh; end
                CLS_MULDIV: begin w.Gra = 1'b1; w.Rout = 1'b1; w.Yin = 1'b1; end
                CLS_BR:     begin w.Gra = 1'b1; w.Rout = 1'b1; w.CONin = 1'b1; end
                CLS_JR:     begin w.Gra = 1'b1; w.Rout = 1'b1; w.PCin = 1'b1; end
                CLS_JAL:    w.PCSave = 1'b1;
                CLS_IN:     begin w.INout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                CLS_OUT:    begin w.Gra = 1'b1; w.Rout = 1'b1; w.OUT_Portin = 1'b1; end
                CLS_MFHI:   begin w.HIout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                CLS_MFLO:   begin w.LOout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                default: ;
            endcase
            ST_T4: case (c)
                CLS_LD, CLS_LDI, CLS_IMM, CLS_ST: begin w.Cout = 1'b1; w.Zin = 1'b1; w.alu = oh; end
                CLS_ALU3:   begin w.Grc = 1'b1; w.Rout = 1'b1; w.Zin = 1'b1; w.alu = oh; end
                CLS_UNARY:  begin w.Zlowout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                CLS_MULDIV: begin w.Grb = 1'b1; w.Rout = 1'b1; w.Zin = 1'b1; w.alu = oh; end
                CLS_BR:     begin w.PCout = 1'b1; w.Yin = 1'b1; end
                CLS_JAL:    begin w.Gra = 1'b1; w.Rout = 1'b1; w.PCin = 1'b1; end
                default: ;
            endcase
            ST_T5: case (c)
                CLS_LDI, CLS_IMM, CLS_ALU3: begin w.Zlowout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                CLS_LD, CLS_ST: begin w.Zlowout = 1'b1; w.MARin = 1'b1; end
                CLS_MULDIV:     begin w.Zlowout = 1'b1; w.LOin = 1'b1; end
                CLS_BR:         begin w.Cout = 1'b1; w.Zin = 1'b1; w.alu = oh; end
                default: ;
            endcase
            ST_T6: case (c)
                CLS_LD:     begin w.Read = 1'b1; w.read_mem = 1'b1; w.MDRin = 1'b1; end
                CLS_ST:     begin w.Gra = 1'b1; w.Rout = 1'b1; w.MDRin = 1'b1; end
                CLS_MULDIV: begin w.Zhighout = 1'b1; w.HIin = 1'b1; end
                CLS_BR:     begin w.Zlowout = con_ff; w.PCin = con_ff; end
                default: ;
            endcase
            ST_T7: case (c)
                CLS_LD: begin w.MDRout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; end
                CLS_ST: w.write_mem = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
        return w;
    endfunction

    // Outputs are registered from the next state so each strobe is glitch-free for its whole step
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = '0;
        stop_seen_d = stop_seen_q;
        if (state_q == ST_T2) op_d = bus.IR[31:27];
        case (state_q)
            ST_RST: if (!hold_q) state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1: begin
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
                else                   state_d = ST_T2;
            end
            ST_HALT: begin
                if (bus.stop)         stop_seen_d = 1'b1;
                else if (stop_seen_q) state_d = ST_T0;
            end
            default: begin
                if (state_q == ST_T2 && cls == CLS_HALT) begin
                    state_d     = ST_HALT;
                    stop_seen_d = bus.stop;
                end else if (state_q == last_step(cls)) begin
                    state_d     = bus.stop ? ST_HALT : ST_T0;
                    stop_seen_d = bus.stop;
                end else if (state_q == ST_T6 && cls == CLS_LD && cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = next_step(state_q);
                end
            end
        endcase
        out_d = ctrl_word(state_d, cls, alu, bus.CON_FF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST;
            op_q        <= OP_NOP;
            cnt_q       <= '0;
            hold_q      <= 1'b1;
            stop_seen_q <= 1'b0;
            out_q       <= CTRL_RESET;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            hold_q      <= 1'b0;
            stop_seen_q <= stop_seen_d;
            out_q       <= out_d;
        end
    end

    assign bus.HIout      = out_q.HIout;
    assign bus.LOout      = out_q.LOout;
    assign bus.Zhighout   = out_q.Zhighout;
    assign bus.Zlowout    = out_q.Zlowout;
    assign bus.PCout      = out_q.PCout;
    assign bus.MDRout     = out_q.MDRout;
    assign bus.INout      = out_q.INout;
    assign bus.Cout       = out_q.Cout;
    assign bus.Rout       = out_q.Rout;
    assign bus.BAout      = out_q.BAout;
    assign bus.HIin       = out_q.HIin;
    assign bus.LOin       = out_q.LOin;
    assign bus.PCin       = out_q.PCin;
    assign bus.IRin       = out_q.IRin;
    assign bus.Zin        = out_q.Zin;
    assign bus.Yin        = out_q.Yin;
    assign bus.MARin      = out_q.MARin;
    assign bus.MDRin      = out_q.MDRin;
    assign bus.Rin        = out_q.Rin;
    assign bus.CONin      = out_q.CONin;
    assign bus.OUT_Portin = out_q.OUT_Portin;
    assign bus.Gra        = out_q.Gra;
    assign bus.Grb        = out_q.Grb;
    assign bus.Grc        = out_q.Grc;
    assign bus.IncPC      = out_q.IncPC;
    assign bus.PCSave     = out_q.PCSave;
    assign bus.AND        = out_q.alu[ALU_AND];
    assign bus.OR         = out_q.alu[ALU_OR];
    assign bus.ADD        = out_q.alu[ALU_ADD];
    assign bus.SUB        = out_q.alu[ALU_SUB];
    assign bus.MUL        = out_q.alu[ALU_MUL];
    assign bus.DIV        = out_q.alu[ALU_DIV];
    assign bus.SHR        = out_q.alu[ALU_SHR];
    assign bus.SHRA       = out_q.alu[ALU_SHRA];
    assign bus.SHL        = out_q.alu[ALU_SHL];
    assign bus.ROR        = out_q.alu[ALU_ROR];
    assign bus.ROL        = out_q.alu[ALU_ROL];
    assign bus.NEG        = out_q.alu[ALU_NEG];
    assign bus.NOT        = out_q.alu[ALU_NOT];
    assign bus.Read       = out_q.Read;
    assign bus.read_mem   = out_q.read_mem;
    assign bus.write_mem  = out_q.write_mem;
    assign bus.CON_RESET  = out_q.CON_RESET;
    assign bus.Run        = out_q.Run;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MEM_WAIT, default 1: number of cycles Read/read_mem are held in each memory-read state.
REQ-002 clk  input  1  single system clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 IR  input  32  instruction register; opcode is IR[31:27].
REQ-005 CON_FF  input  1  branch-condition flag from the datapath.
REQ-006 stop  input  1  pause request, honoured only at instruction boundary.
REQ-007 Bus-source strobes  output  1 each  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, Rout, BAout.
REQ-008 Register-load strobes  output  1 each  HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, Rin, CONin, OUT_Portin.
REQ-009 Selects/ALU ops  output  1 each  Gra, Grb, Grc, IncPC, PCSave, and one-hot AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
REQ-010 Memory/misc  output  1 each  Read, read_mem, write_mem, CON_RESET, Run.

Function
REQ-011 Moore FSM; every output is a pure decode of the present state and latched opcode, asserted for exactly one clock per step.
REQ-012 States: RST, T0, T1, T2, T3..T7, HALT; T1 and T6 memory reads last MEM_WAIT cycles.
REQ-013 Fetch, common to all opcodes: T0 IncPC+MARin+PCin; T1 Read+read_mem+MDRin; T2 MDRout+IRin.
REQ-014 Opcode is latched at end of T2 and drives T3..T7 decode; the package holds the 5-bit encodings (ld 00000 … halt 11011).
REQ-015 ldi/addi-class: T3 Grb+BAout+Yin (addi/andi/ori use Rout instead of BAout); T4 Cout+op+Zin; T5 Zlowout+Gra+Rin.
REQ-016 ld: T3–T4 as ldi; T5 Zlowout+MARin; T6 Read+read_mem+MDRin; T7 MDRout+Gra+Rin.
REQ-017 st: T3–T4 as ldi; T5 Zlowout+MARin; T6 Gra+Rout+MDRin; T7 write_mem.
REQ-018 R-type ALU (add/sub/and/or/shifts/rotates): T3 Grb+Rout+Yin; T4 Grc+Rout+op+Zin; T5 Zlowout+Gra+Rin.
REQ-019 neg/not: T3 Grb+Rout+op+Zin; T4 Zlowout+Gra+Rin.
REQ-020 mul/div: T3 Gra+Rout+Yin; T4 Grb+Rout+op+Zin; T5 Zlowout+LOin; T6 Zhighout+HIin.
REQ-021 br: T3 Gra+Rout+CONin; T4 PCout+Yin; T5 Cout+ADD+Zin; T6 Zlowout+PCin only if CON_FF=1, otherwise no strobes.
REQ-022 jr: T3 Gra+Rout+PCin. jal: T3 PCSave; T4 Gra+Rout+PCin.
REQ-023 in: T3 INout+Gra+Rin. out: T3 Gra+Rout+OUT_Portin. mfhi/mflo: T3 HIout/LOout+Gra+Rin.
REQ-024 nop and any undefined opcode: return to T0 after T2 with no side effects.
REQ-025 The last step of each instruction transitions to T0, unless stop=1 in that cycle, which selects HALT.
REQ-026 halt opcode: after T2, enter HALT; Run=0 and all strobes 0. HALT→T0 only when stop=0 after having been 1, or on reset.
REQ-027 Run=1 in every state except RST and HALT.
REQ-028 At most one ALU op bit is high in any cycle; Gra/Grb/Grc are mutually exclusive.

Reset
REQ-029 reset=1 forces RST immediately (asynchronous) from any state, including mid-instruction; every output is 0 except CON_RESET=1.
REQ-030 The first posedge after reset deassertion stays in RST (CON_RESET=1 for that cycle); the next posedge enters T0.

Structure
REQ-031 Shared package: opcode localparams, state encoding, and MEM_WAIT default; the datapath and benches import it.
REQ-032 One sub-module, cu_decode: combinational opcode→instruction-class decode; the FSM instantiates it.

Verification
REQ-033 ldi R3,0x65(R0): with IR=0x09800065 → T3 Grb+BAout+Yin, T4 Cout+ADD+Zin, T5 Zlowout+Gra+Rin, then T0; 6 cycles total.
REQ-034 ld with MEM_WAIT=3: Read held exactly 3 cycles in both T1 and T6; instruction completes in 12 cycles.
REQ-035 br with CON_FF=0 vs 1: PCin in T6 absent vs present; T3 shows CONin.
REQ-036 reset asserted during T4 of mul: outputs drop to 0 in the same cycle, CON_RESET=1; fetch restarts at T0 two edges after release.
REQ-037 halt opcode (IR[31:27]=11011) → HALT, Run=0, no strobes for 10 cycles; stop 1→0 resumes at T0.
REQ-038 Undefined opcode 11111 → only fetch strobes, back to T0 after T2; one-hot ALU check holds in every cycle.
